prog_rom_loader: RTL

Parametrised, writable program store for the 4-bit RISC processor, replacing the fixed combinational instruction ROM. On reset it fills every location with a fill word. It then serves one-cycle-latency instruction fetches to the control unit. On request it accepts a new program image over a valid/ready stream from the host or test harness, so programs change without resynthesis.

---
 rtl/prog_rom_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_rom_loader.sv
// prog_rom_loader: writable program store for the 4-bit RISC core.
// On reset every word is overwritten with FILL. The store then serves
// single-cycle registered fetches, and a new program image can be
// streamed in over a valid/ready port without resynthesis.
// Optional feature macro: PROG_CHECKSUM_EN adds a trailing checksum word
// per image, a CHK state and a sticky ld_err flag.
module prog_rom_loader #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              busy
);

  // Width of a physical memory index; pointers carry one extra bit so they
  // can represent the full image length DEPTH.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_CHK   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;
`endif

  state_t            state_reg;
  logic [ADDR_W:0]   ptr_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   len_clamped;
  logic              ptr_last;
  logic              fetch_in_range;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
  logic [DATA_W-1:0] chk_sum;
  logic              ld_err_reg;
`endif

  // Requested lengths beyond the store are truncated to the store size.
  assign len_clamped = (ld_len > DEPTH_C) ? DEPTH_C : ld_len;

  // The word being accepted now is the last image word.
  assign ptr_last = ((ptr_reg + 1'b1) == len_reg);

  // Addresses past the physical store read back as FILL.
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_C);

  // Status outputs decode straight from the state register.
  assign busy = (state_reg != ST_RUN);
`ifdef PROG_CHECKSUM_EN
  assign ld_ready = (state_reg == ST_LOAD) || (state_reg == ST_CHK);
  assign chk_sum  = sum_reg + ld_data;
  assign ld_err   = ld_err_reg;
`else
  assign ld_ready = (state_reg == ST_LOAD);
  assign ld_err   = 1'b0;
`endif

  // Single write port: FILL while clearing, image words while loading.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_reg[IDX_W-1:0];
    mem_wdata = FILL;
    if (state_reg == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if ((state_reg == ST_LOAD) && ld_valid) begin
      mem_we    = 1'b1;
      mem_wdata = ld_data;
    end
  end

  // Memory array write; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered fetch port, only active in RUN; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data  <= FILL;
      fetch_valid <= 1'b0;
    end else if ((state_reg == ST_RUN) && fetch_en) begin
      fetch_valid <= 1'b1;
      fetch_data  <= fetch_in_range ? mem[fetch_addr[IDX_W-1:0]] : FILL;
    end else begin
      fetch_valid <= 1'b0;
    end
  end

  // Control FSM: clear sweep, run, image load and optional checksum check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_CLEAR;
      ptr_reg    <= '0;
      len_reg    <= '0;
      ld_done    <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_reg    <= '0;
      ld_err_reg <= 1'b0;
`endif
    end else begin
      ld_done <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (ptr_reg == LAST_C) begin
            state_reg <= ST_RUN;
            ptr_reg   <= '0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end

        ST_RUN: begin
          if (ld_start) begin
            len_reg <= len_clamped;
            ptr_reg <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_reg    <= '0;
            ld_err_reg <= 1'b0;
`endif
            if (len_clamped == '0) begin
`ifdef PROG_CHECKSUM_EN
              // An empty image still carries its checksum word.
              state_reg <= ST_CHK;
`else
              ld_done <= 1'b1;
`endif
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (ld_valid) begin
            ptr_reg <= ptr_reg + 1'b1;
`ifdef PROG_CHECKSUM_EN
            sum_reg <= chk_sum;
            if (ptr_last) begin
              state_reg <= ST_CHK;
            end
`else
            if (ptr_last) begin
              state_reg <= ST_RUN;
              ld_done   <= 1'b1;
            end
`endif
          end
        end

`ifdef PROG_CHECKSUM_EN
        ST_CHK: begin
          // The checksum word is compared, never stored.
          if (ld_valid) begin
            if (chk_sum != '0) begin
              ld_err_reg <= 1'b1;
            end
            state_reg <= ST_RUN;
            ld_done   <= 1'b1;
          end
        end
`endif

        default: begin
          state_reg <= ST_CLEAR;
          ptr_reg   <= '0;
        end
      endcase
    end
  end

endmodule
